pipe_stage_chain: RTL and testbench

- Parametrised, handshaked pipeline backbone holding STAGES payload registers of WIDTH bits, each with its own valid bit.
- Replaces the hard-wired, always-valid inter-stage registers of the current core.
- Adds ready/valid flow control, per-stage stall, and age-ordered flush (branch redirect kills younger stages).
- Sits between fetch (input side) and writeback/retire (output side). Decode/execute/memory logic reads stage contents through the observation bus.

---
 rtl/pipe_pkg.sv | 15 +
 rtl/pipe_stage.sv | 32 +++
 rtl/pipe_stage_chain.sv | 120 ++++++++++++
 tb/tb_pipe_stage_chain.sv | 312 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// Shared constants and types for the handshaked pipeline chain.
package pipe_pkg;

    localparam int STAGES_DEF = 5;
    localparam int WIDTH_DEF  = 64;
    localparam int CNT_W_DEF  = 64;

    // flush_idx must be able to name every stage plus "all stages".
    function automatic int flush_idx_w(input int stages);
        return $clog2(stages) + 1;
    endfunction

    typedef logic [STAGES_DEF-1:0] stage_valid_t;

endpackage

// File: rtl/pipe_stage.sv
// One pipeline slot: valid bit plus payload register with load, bubble and kill controls.
module pipe_stage
    import pipe_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             bubble,
    input  logic             kill,
    input  logic [WIDTH-1:0] up_data,
    output logic             valid,
    output logic [WIDTH-1:0] data
);

    // A bubble clears valid but leaves the previous payload in place.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid <= 1'b0;
            data  <= '0;
        end else if (kill) begin
            valid <= 1'b0;
        end else if (load) begin
            valid <= !bubble;
            if (!bubble) begin
                data <= up_data;
            end
        end
    end

endmodule

// File: rtl/pipe_stage_chain.sv
// Ready/valid pipeline backbone with per-stage stall and age-ordered flush.
// Optional performance counters are built when PIPE_PERF_CNT_EN is defined.
module pipe_stage_chain
    import pipe_pkg::*;
#(
    parameter int STAGES = STAGES_DEF,
    parameter int WIDTH  = WIDTH_DEF
`ifdef PIPE_PERF_CNT_EN
    , parameter int CNT_W = CNT_W_DEF
`endif
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [WIDTH-1:0]              in_data,
    input  logic [STAGES-1:0]             stall_req,
    input  logic                          flush_valid,
    input  logic [flush_idx_w(STAGES)-1:0] flush_idx,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [WIDTH-1:0]              out_data,
    output logic [STAGES-1:0]             stage_valid,
    output logic [STAGES*WIDTH-1:0]       stage_data
`ifdef PIPE_PERF_CNT_EN
    , output logic [CNT_W-1:0]            perf_cycles
    , output logic [CNT_W-1:0]            perf_retired
    , output logic [CNT_W-1:0]            perf_stall
    , output logic [CNT_W-1:0]            perf_flush
`endif
);

    localparam int FIW = flush_idx_w(STAGES);

    logic [STAGES-1:0] valid;
    logic [STAGES-1:0] ready;
    logic [STAGES-1:0] go;
    logic [STAGES-1:0] up_valid;
    logic [STAGES-1:0] bubble;
    logic [STAGES-1:0] kill;
    logic [WIDTH-1:0]  data [STAGES];
    logic              chain_go;

    // Handshake: a transfer happens on any edge where valid && ready; valid never
    // depends on ready, ready flows combinationally from out_ready back to in_ready.
    always_comb begin
        ready    = '0;
        go       = '0;
        up_valid = '0;
        bubble   = '0;
        kill     = '0;
        chain_go = out_ready;
        for (int i = STAGES - 1; i >= 0; i--) begin
            go[i]    = chain_go;
            ready[i] = !stall_req[i] && (!valid[i] || go[i]);
            chain_go = ready[i];
        end
        up_valid[0] = in_valid;
        for (int i = 1; i < STAGES; i++) begin
            up_valid[i] = valid[i-1] && !stall_req[i-1];
        end
        // Stages below flush_idx die; the slot feeding stage flush_idx (and the input) becomes a bubble.
        for (int i = 0; i < STAGES; i++) begin
            kill[i]   = flush_valid && (flush_idx > FIW'(i));
            bubble[i] = !up_valid[i] || (flush_valid && (flush_idx >= FIW'(i)));
        end
    end

    for (genvar i = 0; i < STAGES; i++) begin : g_stage
        logic [WIDTH-1:0] up_data;
        if (i == 0) begin : g_head
            assign up_data = in_data;
        end else begin : g_body
            assign up_data = data[i-1];
        end

        pipe_stage #(
            .WIDTH(WIDTH)
        ) u_stage (
            .clk    (clk),
            .rst    (rst),
            .load   (ready[i]),
            .bubble (bubble[i]),
            .kill   (kill[i]),
            .up_data(up_data),
            .valid  (valid[i]),
            .data   (data[i])
        );

        assign stage_data[i*WIDTH +: WIDTH] = data[i];
    end

    assign in_ready    = ready[0];
    assign out_valid   = valid[STAGES-1];
    assign out_data    = data[STAGES-1];
    assign stage_valid = valid;

`ifdef PIPE_PERF_CNT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_cycles  <= '0;
            perf_retired <= '0;
            perf_stall   <= '0;
            perf_flush   <= '0;
        end else begin
            perf_cycles <= perf_cycles + CNT_W'(1);
            if (out_valid && out_ready) begin
                perf_retired <= perf_retired + CNT_W'(1);
            end
            if (in_valid && !in_ready) begin
                perf_stall <= perf_stall + CNT_W'(1);
            end
            if (flush_valid) begin
                perf_flush <= perf_flush + CNT_W'(1);
            end
        end
    end
`endif

endmodule

// File: tb/tb_pipe_stage_chain.sv
// Scoreboard bench for pipe_stage_chain: streaming, backpressure, stall, flush, reset.
module tb_pipe_stage_chain;
    import pipe_pkg::*;

    localparam int STAGES = STAGES_DEF;
    localparam int WIDTH  = WIDTH_DEF;
    localparam int FIW    = flush_idx_w(STAGES);

    logic                    clk         = 1'b0;
    logic                    rst         = 1'b1;
    logic                    in_valid    = 1'b0;
    logic                    out_ready   = 1'b1;
    logic                    flush_valid = 1'b0;
    logic [WIDTH-1:0]        in_data     = '0;
    logic [STAGES-1:0]       stall_req   = '0;
    logic [FIW-1:0]          flush_idx   = '0;
    logic                    in_ready;
    logic                    out_valid;
    logic [WIDTH-1:0]        out_data;
    stage_valid_t            stage_valid;
    logic [STAGES*WIDTH-1:0] stage_data;
`ifdef PIPE_PERF_CNT_EN
    logic [CNT_W_DEF-1:0] perf_cycles, perf_retired, perf_stall, perf_flush;
    logic [CNT_W_DEF-1:0] m_cycles = '0, m_retired = '0, m_stall = '0, m_flush = '0;
`endif

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    bit chk_lat = 1'b0;
    int acc_v;
    logic [WIDTH-1:0] exp_q[$];
    int               acc_q[$];

    pipe_stage_chain dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .stall_req  (stall_req),
        .flush_valid(flush_valid),
        .flush_idx  (flush_idx),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .stage_valid(stage_valid),
        .stage_data (stage_data)
`ifdef PIPE_PERF_CNT_EN
        , .perf_cycles (perf_cycles)
        , .perf_retired(perf_retired)
        , .perf_stall  (perf_stall)
        , .perf_flush  (perf_flush)
`endif
    );

    // clock / reset
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", tag, got, exp, $time);
        end
    endtask

    // scoreboard: push on accepted input, pop/compare on output handshake
    always @(negedge clk) begin
        if (!rst) begin
            if (in_valid && in_ready && !flush_valid) begin
                exp_q.push_back(in_data);
                acc_q.push_back(cyc);
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    check("out_unexpected_qsize", 64'(exp_q.size()), 64'd1);
                end else begin
                    check("out_data", out_data, exp_q.pop_front());
                    acc_v = acc_q.pop_front();
                    if (chk_lat) check("latency", 64'(cyc - acc_v), 64'(STAGES));
                end
            end
        end
    end

`ifdef PIPE_PERF_CNT_EN
    always @(posedge clk) m_cycles <= rst ? '0 : m_cycles + 1'b1;
    always @(negedge clk) begin
        if (rst) begin
            m_retired <= '0;
            m_stall   <= '0;
            m_flush   <= '0;
        end else begin
            if (out_valid && out_ready) m_retired <= m_retired + 1'b1;
            if (in_valid && !in_ready) m_stall <= m_stall + 1'b1;
            if (flush_valid) m_flush <= m_flush + 1'b1;
        end
    end
`endif

    // driver tasks
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [WIDTH-1:0] d);
        bit ok = 1'b0;
        in_valid = 1'b1;
        in_data  = d;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (in_ready) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) check("send_accept", 64'(in_ready), 64'd1);
        tick();
        in_valid = 1'b0;
    endtask

    task automatic flush_cycle(input int idx, input bit with_in, input logic [WIDTH-1:0] d);
        flush_valid = 1'b1;
        flush_idx   = FIW'(idx);
        in_valid    = with_in;
        in_data     = d;
        @(negedge clk);
        if (with_in) check("flush_in_ready", 64'(in_ready), 64'd1);
        tick();
        flush_valid = 1'b0;
        in_valid    = 1'b0;
    endtask

    task automatic drain(input string tag);
        for (int k = 0; k < 60; k++) begin
            if (exp_q.size() == 0) break;
            @(posedge clk);
        end
        #1;
        check(tag, 64'(exp_q.size()), 64'd0);
        repeat (STAGES + 1) tick();
        check({tag, "_empty"}, 64'(stage_valid), 64'd0);
    endtask

    initial begin
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        @(negedge clk);
        check("rst_in_ready", 64'(in_ready), 64'd1);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_stage_valid", 64'(stage_valid), 64'd0);
        check("rst_out_data", out_data, 64'd0);
        tick();

        // streaming: back-to-back, fixed latency
        chk_lat = 1'b1;
        for (int k = 1; k <= 3; k++) send(WIDTH'(k));
        drain("stream_drain");
        chk_lat = 1'b0;

        // backpressure: fill, hold, release
        out_ready = 1'b0;
        for (int k = 0; k < STAGES; k++) send(WIDTH'(16 + k));
        @(negedge clk);
        check("bp_in_ready", 64'(in_ready), 64'd0);
        check("bp_out_valid", 64'(out_valid), 64'd1);
        check("bp_stage_valid", 64'(stage_valid), 64'h1f);
        for (int k = 0; k < 3; k++) begin
            tick();
            @(negedge clk);
            check("bp_hold", out_data, 64'h10);
        end
        tick();
        out_ready = 1'b1;
        @(negedge clk);
        check("bp_release_in_ready", 64'(in_ready), 64'd1);
        for (int k = 0; k < STAGES; k++) begin
            check("bp_drain_valid", 64'(out_valid), 64'd1);
            tick();
            @(negedge clk);
        end
        tick();
        drain("bp_drain");

        // stall stage 2 for 3 cycles mid-stream
        fork
            begin
                for (int k = 0; k < 8; k++) send(WIDTH'(32 + k));
            end
            begin
                repeat (3) @(posedge clk);
                #1;
                stall_req = 5'b00100;
                @(negedge clk);
                check("stall_in_ready", 64'(in_ready), 64'd0);
                tick();
                @(negedge clk);
                check("stall_bubble_s3", 64'(stage_valid[3]), 64'd0);
                check("stall_frozen", 64'(stage_valid[2:0]), 64'h7);
                tick();
                tick();
                stall_req = '0;
            end
        join
        drain("stall_drain");

        // flush idx 2 with stages D,C,B,A and incoming E
        send(64'hD);
        send(64'hC);
        send(64'hB);
        send(64'hA);
        flush_cycle(2, 1'b1, 64'hE);
        void'(exp_q.pop_back());
        void'(exp_q.pop_back());
        void'(acc_q.pop_back());
        void'(acc_q.pop_back());
        @(negedge clk);
        check("flush_stage_valid", 64'(stage_valid), 64'h18);
        check("flush_stage3", stage_data[3*WIDTH +: WIDTH], 64'hC);
        check("flush_stage4", stage_data[4*WIDTH +: WIDTH], 64'hD);
        tick();
        drain("flush_drain");

        // flush idx 0 drops only the incoming payload
        send(64'h51);
        flush_cycle(0, 1'b1, 64'h52);
        send(64'h53);
        drain("flush0_drain");

        // flush idx >= STAGES kills everything; out handshake still completes
        out_ready = 1'b0;
        for (int k = 0; k < STAGES; k++) send(WIDTH'(96 + k));
        out_ready = 1'b1;
        flush_cycle(7, 1'b0, '0);
        exp_q.delete();
        acc_q.delete();
        @(negedge clk);
        check("flush_all_valid", 64'(stage_valid), 64'd0);
        check("flush_all_out_valid", 64'(out_valid), 64'd0);
        tick();

        // flush beats stall on the same stage
        send(64'h71);
        send(64'h72);
        stall_req = 5'b00010;
        flush_cycle(2, 1'b0, '0);
        stall_req = '0;
        exp_q.delete();
        acc_q.delete();
        @(negedge clk);
        check("flush_stall_valid", 64'(stage_valid), 64'd0);
        tick();
        drain("flush_stall_drain");

        // reset with a full chain
        out_ready = 1'b0;
        for (int k = 0; k < STAGES; k++) send(WIDTH'(128 + k));
        rst = 1'b1;
        exp_q.delete();
        acc_q.delete();
        tick();
        rst = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        check("rst_mid_stage_valid", 64'(stage_valid), 64'd0);
        check("rst_mid_out_valid", 64'(out_valid), 64'd0);
        check("rst_mid_in_ready", 64'(in_ready), 64'd1);
        tick();
        chk_lat = 1'b1;
        send(64'h99);
        drain("rst_mid_drain");
        chk_lat = 1'b0;

`ifdef PIPE_PERF_CNT_EN
        // some input backpressure and two flushes for the counters
        out_ready = 1'b0;
        for (int k = 0; k < STAGES; k++) send(WIDTH'(160 + k));
        in_valid = 1'b1;
        in_data  = 64'hff;
        repeat (3) tick();
        in_valid  = 1'b0;
        out_ready = 1'b1;
        flush_cycle(1, 1'b0, '0);
        flush_cycle(0, 1'b0, '0);
        void'(exp_q.pop_back());
        void'(acc_q.pop_back());
        drain("perf_drain");
        @(negedge clk);
        check("perf_cycles", perf_cycles, m_cycles);
        check("perf_retired", perf_retired, m_retired);
        check("perf_stall", perf_stall, m_stall);
        check("perf_flush", perf_flush, m_flush);
        tick();
`endif

        check("final_queue", 64'(exp_q.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
